// File: rtl/gray_step_monitor.sv
// Registered Gray-to-binary decoder with +/-1 step checking, lock tracking and a saturating error count.
// Optional macro GRAY_STEP_WRAP_EN: treat 15->0 / 0->15 as legal steps (cyclic source).
module gray_step_monitor #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 G3,
    input  logic                 G2,
    input  logic                 G1,
    input  logic                 G0,
    input  logic                 GV,
    output logic                 B3,
    output logic                 B2,
    output logic                 B1,
    output logic                 B0,
    output logic                 BV,
    output logic                 DIR,
    output logic                 ERR,
    output logic [ERR_CNT_W-1:0] ERRCNT,
    output logic                 LOCK
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_LOCK} state_t;

    state_t               state_q, state_d;
    logic [3:0]           b_q, b_d;
    logic [1:0]           good_q, good_d;
    logic                 bv_q, bv_d;
    logic                 dir_q, dir_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;

    logic [3:0] dec;
    logic [3:0] prev_inc, prev_dec;
    logic       up_ok, dn_ok;
    logic       is_up, is_dn, is_rep, is_jump;

    assign dec[3] = G3;
    assign dec[2] = dec[3] ^ G2;
    assign dec[1] = dec[2] ^ G1;
    assign dec[0] = dec[1] ^ G0;

    assign prev_inc = b_q + 4'd1;
    assign prev_dec = b_q - 4'd1;

`ifdef GRAY_STEP_WRAP_EN
    assign up_ok = 1'b1;
    assign dn_ok = 1'b1;
`else
    // Linear source: the modular wrap between 15 and 0 is not a real step.
    assign up_ok = (b_q != 4'hF);
    assign dn_ok = (b_q != 4'h0);
`endif

    assign is_up   = (dec == prev_inc) && up_ok;
    assign is_dn   = (dec == prev_dec) && dn_ok;
    assign is_rep  = (dec == b_q);
    assign is_jump = !(is_up || is_dn || is_rep);

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        good_d   = good_q;
        bv_d     = 1'b0;
        dir_d    = dir_q;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;

        if (GV) begin
            b_d  = dec;
            bv_d = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                    good_d  = 2'd0;
                end
                ST_ACQ: begin
                    if (is_jump) begin
                        err_d  = 1'b1;
                        good_d = 2'd0;
                    end else if (is_up || is_dn) begin
                        dir_d  = is_up;
                        good_d = good_q + 2'd1;
                        if (good_q == 2'd1) begin
                            state_d = ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    if (is_jump) begin
                        err_d   = 1'b1;
                        good_d  = 2'd0;
                        state_d = ST_ACQ;
                    end else if (is_up || is_dn) begin
                        dir_d = is_up;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (err_d && (errcnt_q != {ERR_CNT_W{1'b1}})) begin
            errcnt_d = errcnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            b_q      <= 4'd0;
            good_q   <= 2'd0;
            bv_q     <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            good_q   <= good_d;
            bv_q     <= bv_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign {B3, B2, B1, B0} = b_q;
    assign BV     = bv_q;
    assign DIR    = dir_q;
    assign ERR    = err_q;
    assign ERRCNT = errcnt_q;
    assign LOCK   = (state_q == ST_LOCK);

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: default-width and 2-bit-counter instances checked every cycle against a model.
module tb_gray_step_monitor;

    logic       CLK = 1'b0;
    logic       RST, GV;
    logic [3:0] G;

    logic       a_b3, a_b2, a_b1, a_b0, a_bv, a_dir, a_err, a_lock;
    logic [7:0] a_cnt;
    logic       c_b3, c_b2, c_b1, c_b0, c_bv, c_dir, c_err, c_lock;
    logic [1:0] c_cnt;

    int checks = 0;
    int errors = 0;

`ifdef GRAY_STEP_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    always #5 CLK = ~CLK;

    gray_step_monitor u8 (
        .CLK(CLK), .RST(RST), .G3(G[3]), .G2(G[2]), .G1(G[1]), .G0(G[0]), .GV(GV),
        .B3(a_b3), .B2(a_b2), .B1(a_b1), .B0(a_b0), .BV(a_bv), .DIR(a_dir),
        .ERR(a_err), .ERRCNT(a_cnt), .LOCK(a_lock)
    );

    gray_step_monitor #(.ERR_CNT_W(2)) u2 (
        .CLK(CLK), .RST(RST), .G3(G[3]), .G2(G[2]), .G1(G[1]), .G0(G[0]), .GV(GV),
        .B3(c_b3), .B2(c_b2), .B1(c_b1), .B0(c_b0), .BV(c_bv), .DIR(c_dir),
        .ERR(c_err), .ERRCNT(c_cnt), .LOCK(c_lock)
    );

    // Behavioural model: tracks value, streak of legal moves and total error count.
    bit started = 0;
    bit have_ref, m_bv, m_dir, m_err, m_lock;
    int m_b, good, errs;

    always @(posedge CLK) begin
        int v, d;
        bit up, dn;
        if (RST) begin
            started = 1; have_ref = 0; m_b = 0; m_bv = 0; m_dir = 0;
            m_err = 0; m_lock = 0; good = 0; errs = 0;
        end else if (GV) begin
            v = 0;
            for (int s = 0; s < 4; s++) v = v ^ (int'(G) >> s);
            m_bv = 1; m_err = 0;
            if (have_ref) begin
                d  = (v - m_b + 16) % 16;
                up = (d == 1) && (WRAP || m_b != 15);
                dn = (d == 15) && (WRAP || m_b != 0);
                if (up || dn) begin
                    m_dir = up;
                    good++;
                    if (good >= 2) m_lock = 1;
                end else if (d != 0) begin
                    m_err = 1; errs++; good = 0; m_lock = 0;
                end
            end
            have_ref = 1;
            m_b = v;
        end else begin
            m_bv = 0; m_err = 0;
        end
    end

    always @(negedge CLK) begin
        logic [7:0] act, exp;
        if (started) begin
            exp = {m_b[3:0], m_bv, m_dir, m_err, m_lock};
            act = {a_b3, a_b2, a_b1, a_b0, a_bv, a_dir, a_err, a_lock};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_w8 t=%0t got {B,BV,DIR,ERR,LOCK}=%b want %b", $time, act, exp);
            end
            act = {c_b3, c_b2, c_b1, c_b0, c_bv, c_dir, c_err, c_lock};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_w2 t=%0t got {B,BV,DIR,ERR,LOCK}=%b want %b", $time, act, exp);
            end
            checks++;
            if (a_cnt !== 8'((errs > 255) ? 255 : errs) || c_cnt !== 2'((errs > 3) ? 3 : errs)) begin
                errors++;
                $display("FAIL model_errcnt t=%0t got w8=%0d w2=%0d want errs=%0d (saturated)",
                         $time, a_cnt, c_cnt, errs);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] g, input logic gv, input logic rst);
        G = g; GV = gv; RST = rst;
        @(posedge CLK);
        #2;
    endtask

    function automatic int bval();
        return int'({a_b3, a_b2, a_b1, a_b0});
    endfunction

    initial begin
        int exp2[5] = '{1, 2, 3, 3, 3};
        apply(4'b0000, 1'b0, 1'b1);
        apply(4'b0000, 1'b1, 1'b1);
        chk("reset_B", bval(), 0);
        chk("reset_flags", int'({a_bv, a_dir, a_err, a_lock}), 0);
        chk("reset_errcnt", int'(a_cnt), 0);

        // Ramp 0,1,2 acquires lock.
        apply(4'b0000, 1'b1, 1'b0);
        chk("t1_first_bv", int'(a_bv), 1);
        chk("t1_first_lock", int'(a_lock), 0);
        apply(4'b0001, 1'b1, 1'b0);
        chk("t1_b1", bval(), 1);
        apply(4'b0011, 1'b1, 1'b0);
        chk("t1_b2", bval(), 2);
        chk("t1_lock_dir_err", int'({a_lock, a_dir, a_err}), 3'b110);

        apply(4'b0010, 1'b1, 1'b0);
        chk("t2_up_b", bval(), 3);
        chk("t2_up_dir", int'(a_dir), 1);
        apply(4'b0011, 1'b1, 1'b0);
        chk("t2_dn_b", bval(), 2);
        chk("t2_dn_dir_lock", int'({a_dir, a_lock}), 2'b01);
        apply(4'b1111, 1'b0, 1'b0);
        chk("idle_hold", int'({bval(), a_bv, a_err}), {4'd2, 2'b00});

        // Lock on a down ramp 3,2,1 then jump to 14.
        apply(4'b0000, 1'b0, 1'b1);
        apply(4'b0010, 1'b1, 1'b0);
        apply(4'b0011, 1'b1, 1'b0);
        apply(4'b0001, 1'b1, 1'b0);
        chk("t3_locked", int'({bval(), a_lock}), {4'd1, 1'b1});
        apply(4'b1001, 1'b1, 1'b0);
        chk("t3_jump", int'({bval(), a_err, a_lock}), {4'd14, 2'b10});
        chk("t3_cnt1", int'(a_cnt), 1);
        apply(4'b1000, 1'b1, 1'b0);
        chk("t3_b15", int'({bval(), a_err}), {4'd15, 1'b0});
        apply(4'b1100, 1'b1, 1'b0);
        chk("t3_jump2", int'({bval(), a_err}), {4'd8, 1'b1});
        chk("t3_cnt2", int'(a_cnt), 2);

        // 14,15,0 across the wrap point.
        apply(4'b0000, 1'b0, 1'b1);
        apply(4'b1001, 1'b1, 1'b0);
        apply(4'b1000, 1'b1, 1'b0);
        apply(4'b0000, 1'b1, 1'b0);
`ifdef GRAY_STEP_WRAP_EN
        chk("t4_wrap", int'({a_err, a_cnt, a_lock, a_dir}), {1'b0, 8'd0, 2'b11});
`else
        chk("t4_wrap", int'({a_err, a_cnt, a_lock}), {1'b1, 8'd1, 1'b0});
`endif

        // Five jumps alternating 0 <-> 8: 2-bit counter saturates at 3.
        apply(4'b0000, 1'b0, 1'b1);
        apply(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply((i % 2 == 0) ? 4'b1100 : 4'b0000, 1'b1, 1'b0);
            chk("t5_cnt_w2", int'(c_cnt), exp2[i]);
            chk("t5_cnt_w8", int'(a_cnt), i + 1);
        end
        apply(4'b1101, 1'b1, 1'b0);
        apply(4'b1111, 1'b1, 1'b0);
        chk("t6_pre", int'({bval(), a_lock, a_cnt}), {4'd10, 1'b1, 8'd5});

        // Reset wins over a coincident sample; the next sample is a fresh reference.
        apply(4'b0101, 1'b1, 1'b1);
        chk("t6_rst_all", int'({bval(), a_bv, a_dir, a_err, a_lock, a_cnt}), 0);
        apply(4'b0101, 1'b1, 1'b0);
        chk("t6_first", int'({bval(), a_bv, a_err, a_lock}), {4'd6, 3'b100});
        apply(4'b0000, 1'b0, 1'b0);
        apply(4'b0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
